// File: rtl/ddr_step_sequencer.sv
// ddr_step_sequencer
// Step sequencer for the arrow display. A prescaler divides clk into step
// ticks, and each tick fires the next of 8 slots. A firing slot publishes its
// index and its arrow pattern from a writable 8-entry table. The control FSM
// handles start, pause, stop, round counting and song completion.
//
//   state   | meaning
//   --------+-------------------------------------------------------------
//   S_IDLE  | waiting for start; step/arrow cleared
//   S_RUN   | prescaler counting, slots fire on terminal count
//   S_PAUSE | pause held; prescaler, pointer and rounds frozen
//   S_DONE  | ROUNDS passes completed; step/arrow hold slot-7 values
module ddr_step_sequencer #(
  parameter int TICK_DIV = 4,   // clocks per step, 1..255
  parameter int ROUNDS   = 2    // passes through all 8 slots, 1..15
) (
  input  logic       i_clk,
  input  logic       i_rst,
  input  logic       i_start,
  input  logic       i_pause,
  input  logic       i_stop,
  input  logic       i_wr_en,
  input  logic [2:0] i_wr_addr,
  input  logic [3:0] i_wr_data,
  output logic [2:0] o_step,
  output logic [3:0] o_arrow,
  output logic       o_step_strobe,
  output logic       o_round_done,
  output logic       o_busy,
  output logic       o_done
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_RUN   = 2'd1,
    S_PAUSE = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  localparam logic [7:0] LP_TICK_LAST  = 8'(TICK_DIV - 1);
  localparam logic [3:0] LP_ROUND_LAST = 4'(ROUNDS - 1);

  state_t     r_state;
  state_t     w_next;

  logic [7:0] r_presc;
  logic [2:0] r_ptr;
  logic [3:0] r_round;
  logic [3:0] r_tbl [8];

  logic [7:0] w_presc_nxt;
  logic [2:0] w_ptr_nxt;
  logic [3:0] w_round_nxt;
  logic [2:0] w_step_nxt;
  logic [3:0] w_arrow_nxt;
  logic       w_strobe_nxt;
  logic       w_rd_nxt;
  logic       w_busy_nxt;
  logic       w_done_nxt;

  logic       w_active;
  logic       w_fire;
  logic       w_last_fire;
  logic       w_restart;

  // The sequencer advances in RUN, and also on the edge that leaves PAUSE,
  // so a pause of N cycles delays the next strobe by exactly N cycles.
  assign w_active    = ((r_state == S_RUN) || (r_state == S_PAUSE)) && !i_pause;
  assign w_fire      = w_active && (r_presc == LP_TICK_LAST);
  assign w_last_fire = w_fire && (r_ptr == 3'd7) && (r_round == LP_ROUND_LAST);
  assign w_restart   = i_start && ((r_state == S_IDLE) || (r_state == S_DONE));

  // State register.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  // Next-state logic; stop outranks pause, pause outranks tick, tick outranks start.
  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE: begin
        if (i_start && !i_stop) begin
          w_next = S_RUN;
        end
      end
      S_RUN, S_PAUSE: begin
        if (i_stop) begin
          w_next = S_IDLE;
        end else if (i_pause) begin
          w_next = S_PAUSE;
        end else if (w_last_fire) begin
          w_next = S_DONE;
        end else begin
          w_next = S_RUN;
        end
      end
      S_DONE: begin
        if (i_stop) begin
          w_next = S_IDLE;
        end else if (i_start) begin
          w_next = S_RUN;
        end
      end
      default: w_next = S_IDLE;
    endcase
  end

  // Output and counter next values; everything is registered below.
  always_comb begin
    w_presc_nxt  = r_presc;
    w_ptr_nxt    = r_ptr;
    w_round_nxt  = r_round;
    w_step_nxt   = o_step;
    w_arrow_nxt  = o_arrow;
    w_strobe_nxt = 1'b0;
    w_rd_nxt     = 1'b0;
    w_busy_nxt   = (w_next == S_RUN) || (w_next == S_PAUSE);
    w_done_nxt   = (w_next == S_DONE);

    if (i_stop) begin
      w_presc_nxt = 8'd0;
      w_ptr_nxt   = 3'd0;
      w_round_nxt = 4'd0;
      w_step_nxt  = 3'd0;
      w_arrow_nxt = 4'd0;
    end else if (w_restart) begin
      w_presc_nxt = 8'd0;
      w_ptr_nxt   = 3'd0;
      w_round_nxt = 4'd0;
    end else if (w_active) begin
      if (w_fire) begin
        w_step_nxt   = r_ptr;
        w_arrow_nxt  = r_tbl[r_ptr];
        w_strobe_nxt = 1'b1;
        w_ptr_nxt    = r_ptr + 3'd1;
        w_presc_nxt  = 8'd0;
        if (r_ptr == 3'd7) begin
          w_rd_nxt = 1'b1;
          if (r_round != LP_ROUND_LAST) begin
            w_round_nxt = r_round + 4'd1;
          end
        end
      end else begin
        w_presc_nxt = r_presc + 8'd1;
      end
    end
  end

  // Counter and output registers.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_presc       <= 8'd0;
      r_ptr         <= 3'd0;
      r_round       <= 4'd0;
      o_step        <= 3'd0;
      o_arrow       <= 4'd0;
      o_step_strobe <= 1'b0;
      o_round_done  <= 1'b0;
      o_busy        <= 1'b0;
      o_done        <= 1'b0;
    end else begin
      r_presc       <= w_presc_nxt;
      r_ptr         <= w_ptr_nxt;
      r_round       <= w_round_nxt;
      o_step        <= w_step_nxt;
      o_arrow       <= w_arrow_nxt;
      o_step_strobe <= w_strobe_nxt;
      o_round_done  <= w_rd_nxt;
      o_busy        <= w_busy_nxt;
      o_done        <= w_done_nxt;
    end
  end

  // Pattern table; the firing slot reads the old entry on a same-edge write.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      for (int i = 0; i < 8; i++) begin
        r_tbl[i] <= 4'd0;
      end
    end else if (i_wr_en) begin
      r_tbl[i_wr_addr] <= i_wr_data;
    end
  end

endmodule

// File: tb/tb_ddr_step_sequencer.sv
// Testbench for ddr_step_sequencer: directed scenarios plus randomized traffic
// checked cycle by cycle against a song-level reference model.
module tb_ddr_step_sequencer;

  localparam int TD = 4;
  localparam int RN = 2;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       start = 1'b0, pause = 1'b0, stop = 1'b0;
  logic       wr_en = 1'b0;
  logic [2:0] wr_addr = 3'd0;
  logic [3:0] wr_data = 4'd0;
  logic [2:0] step;
  logic [3:0] arrow;
  logic       strobe, round_done, busy, done;

  int n_checks = 0;
  int n_errors = 0;

  // Reference model: song position as a count of active clocks since start.
  int         m_mode;     // 0 idle, 1 running (incl. paused), 2 done
  int         m_act;
  logic [2:0] m_step;
  logic [3:0] m_arrow;
  logic       m_strobe, m_rd;
  logic [3:0] m_tbl [8];

  ddr_step_sequencer #(.TICK_DIV(TD), .ROUNDS(RN)) dut (
    .i_clk(clk), .i_rst(rst), .i_start(start), .i_pause(pause), .i_stop(stop),
    .i_wr_en(wr_en), .i_wr_addr(wr_addr), .i_wr_data(wr_data),
    .o_step(step), .o_arrow(arrow), .o_step_strobe(strobe),
    .o_round_done(round_done), .o_busy(busy), .o_done(done)
  );

  always #5 clk = ~clk;

  task automatic model_reset();
    m_mode = 0; m_act = 0; m_step = 3'd0; m_arrow = 4'd0;
    m_strobe = 1'b0; m_rd = 1'b0;
    for (int i = 0; i < 8; i++) m_tbl[i] = 4'd0;
  endtask

  task automatic model_update();
    int k;
    m_strobe = 1'b0;
    m_rd     = 1'b0;
    if (stop) begin
      m_mode = 0; m_act = 0; m_step = 3'd0; m_arrow = 4'd0;
    end else if (m_mode != 1) begin
      if (start) begin m_mode = 1; m_act = 0; end
    end else if (!pause) begin
      m_act++;
      if (m_act % TD == 0) begin
        k        = m_act / TD - 1;
        m_step   = 3'(k % 8);
        m_arrow  = m_tbl[k % 8];
        m_strobe = 1'b1;
        m_rd     = (k % 8 == 7);
        if (k == 8 * RN - 1) m_mode = 2;
      end
    end
    if (wr_en) m_tbl[wr_addr] = wr_data;
  endtask

  // One clock: advance the model with the current inputs, then sample after the edge.
  task automatic cyc();
    model_update();
    @(posedge clk);
    #1;
  endtask

  task automatic write_tbl(input logic [2:0] a, input logic [3:0] d);
    wr_en = 1'b1; wr_addr = a; wr_data = d;
    cyc();
    wr_en = 1'b0;
  endtask

  task automatic pulse_start();
    start = 1'b1;
    cyc();
    start = 1'b0;
  endtask

  task automatic pulse_stop();
    stop = 1'b1;
    cyc();
    stop = 1'b0;
  endtask

  task automatic test_reset();
    model_reset();
    #1;
    n_checks++;
    if ({step, arrow, strobe, round_done, busy, done} !== 11'd0) begin
      $display("FAIL reset_init: outputs=%b required 0", {step, arrow, strobe, round_done, busy, done});
      n_errors++;
    end
    @(posedge clk); #1;
    rst = 1'b0;
    for (int i = 0; i < 8; i++) write_tbl(3'(i), 4'hF);
    pulse_start();
    for (int c = 1; c <= 6; c++) cyc();
    n_checks++;
    if (arrow !== 4'hF || busy !== 1'b1) begin
      $display("FAIL reset_prerun: arrow=%h busy=%b required F 1", arrow, busy);
      n_errors++;
    end
    #3 rst = 1'b1;
    #1;
    n_checks++;
    if ({step, arrow, strobe, round_done, busy, done} !== 11'd0) begin
      $display("FAIL reset_async: outputs=%b required 0", {step, arrow, strobe, round_done, busy, done});
      n_errors++;
    end
    model_reset();
    @(posedge clk); #1;
    rst = 1'b0;
    pulse_start();
    for (int c = 1; c <= 12; c++) begin
      cyc();
      if (c % TD == 0) begin
        n_checks++;
        if (strobe !== 1'b1 || arrow !== 4'd0) begin
          $display("FAIL reset_table_clear c=%0d: strobe=%b arrow=%b required 1 0000", c, strobe, arrow);
          n_errors++;
        end
      end
    end
    pulse_stop();
  endtask

  task automatic test_song();
    logic [3:0] pat [8];
    logic exp_s;
    int idx;
    pat = '{4'd8, 4'd4, 4'd2, 4'd1, 4'd8, 4'd4, 4'd2, 4'd1};
    for (int i = 0; i < 8; i++) write_tbl(3'(i), pat[i]);
    pulse_start();
    for (int c = 1; c <= 72; c++) begin
      cyc();
      exp_s = (c % TD == 0) && (c <= 16 * TD);
      idx   = c / TD - 1;
      n_checks++;
      if (strobe !== exp_s) begin
        $display("FAIL song_strobe c=%0d: got %b required %b", c, strobe, exp_s);
        n_errors++;
      end
      n_checks++;
      if (round_done !== (exp_s && (idx % 8 == 7))) begin
        $display("FAIL song_round_done c=%0d: got %b required %b", c, round_done, exp_s && (idx % 8 == 7));
        n_errors++;
      end
      if (exp_s) begin
        n_checks++;
        if (step !== 3'(idx % 8) || arrow !== pat[idx % 8]) begin
          $display("FAIL song_slot c=%0d: step=%0d arrow=%b required %0d %b", c, step, arrow, idx % 8, pat[idx % 8]);
          n_errors++;
        end
      end
      n_checks++;
      if (busy !== (c < 16 * TD) || done !== (c >= 16 * TD)) begin
        $display("FAIL song_state c=%0d: busy=%b done=%b required %b %b", c, busy, done, c < 16 * TD, c >= 16 * TD);
        n_errors++;
      end
    end
    n_checks++;
    if (step !== 3'd7 || arrow !== 4'd1) begin
      $display("FAIL song_done_hold: step=%0d arrow=%b required 7 0001", step, arrow);
      n_errors++;
    end
    pulse_stop();
  endtask

  task automatic test_pause_stop();
    logic exp_s;
    pulse_start();
    for (int c = 1; c <= 26; c++) begin
      pause = (c >= 11 && c <= 20);
      cyc();
      exp_s = (c == 4 || c == 8 || c == 22 || c == 26);
      n_checks++;
      if (strobe !== exp_s) begin
        $display("FAIL pause_strobe c=%0d: got %b required %b", c, strobe, exp_s);
        n_errors++;
      end
      if (c >= 11 && c <= 20) begin
        n_checks++;
        if (step !== 3'd1 || arrow !== 4'd4 || busy !== 1'b1) begin
          $display("FAIL pause_hold c=%0d: step=%0d arrow=%b busy=%b required 1 0100 1", c, step, arrow, busy);
          n_errors++;
        end
      end
    end
    pause = 1'b1;
    cyc(); cyc();
    stop = 1'b1;
    cyc();
    stop = 1'b0; pause = 1'b0;
    n_checks++;
    if (busy !== 1'b0 || arrow !== 4'd0 || step !== 3'd0 || done !== 1'b0) begin
      $display("FAIL stop_in_pause: busy=%b arrow=%b step=%0d done=%b required 0 0 0 0", busy, arrow, step, done);
      n_errors++;
    end
    pulse_start();
    for (int c = 1; c <= TD; c++) begin
      cyc();
      n_checks++;
      if (strobe !== (c == TD)) begin
        $display("FAIL stop_restart_strobe c=%0d: got %b required %b", c, strobe, c == TD);
        n_errors++;
      end
    end
    n_checks++;
    if (step !== 3'd0 || arrow !== 4'd8) begin
      $display("FAIL stop_restart_slot: step=%0d arrow=%b required 0 1000", step, arrow);
      n_errors++;
    end
    pulse_stop();
  endtask

  task automatic test_read_before_write();
    pulse_start();
    for (int c = 1; c <= 12 * TD; c++) begin
      if (c == 4 * TD) begin wr_en = 1'b1; wr_addr = 3'd3; wr_data = 4'hF; end
      cyc();
      wr_en = 1'b0;
      if (c == 4 * TD || c == 12 * TD) begin
        n_checks++;
        if (step !== 3'd3 || arrow !== ((c == 4 * TD) ? 4'b0001 : 4'b1111)) begin
          $display("FAIL rbw c=%0d: step=%0d arrow=%b required 3 %b", c, step, arrow, (c == 4 * TD) ? 4'b0001 : 4'b1111);
          n_errors++;
        end
      end
    end
    pulse_stop();
  endtask

  task automatic test_idle_done_start();
    int seen;
    start = 1'b1; stop = 1'b1;
    cyc();
    start = 1'b0; stop = 1'b0;
    seen = 0;
    for (int c = 1; c <= 3 * TD; c++) begin
      cyc();
      if (strobe || busy) seen++;
    end
    n_checks++;
    if (seen != 0) begin
      $display("FAIL start_stop_idle: active cycles=%0d required 0", seen);
      n_errors++;
    end
    pulse_start();
    for (int c = 1; c <= 16 * TD + 2; c++) cyc();
    n_checks++;
    if (done !== 1'b1) begin
      $display("FAIL done_reached: done=%b required 1", done);
      n_errors++;
    end
    pause = 1'b1;
    pulse_start();
    pause = 1'b0;
    n_checks++;
    if (done !== 1'b0 || busy !== 1'b1) begin
      $display("FAIL done_restart: done=%b busy=%b required 0 1", done, busy);
      n_errors++;
    end
    for (int c = 1; c <= TD; c++) begin
      cyc();
      n_checks++;
      if (strobe !== (c == TD) || (c == TD && step !== 3'd0)) begin
        $display("FAIL done_restart_fire c=%0d: strobe=%b step=%0d required %b 0", c, strobe, step, c == TD);
        n_errors++;
      end
    end
  endtask

  task automatic test_random();
    for (int c = 0; c < 4000; c++) begin
      start   = ($urandom_range(0, 9) == 0);
      stop    = ($urandom_range(0, 149) == 0);
      pause   = ($urandom_range(0, 5) == 0) ? ~pause : pause;
      wr_en   = ($urandom_range(0, 7) == 0);
      wr_addr = 3'($urandom_range(0, 7));
      wr_data = 4'($urandom_range(0, 15));
      cyc();
      n_checks++;
      if (step !== m_step || arrow !== m_arrow || strobe !== m_strobe || round_done !== m_rd ||
          busy !== (m_mode == 1) || done !== (m_mode == 2)) begin
        $display("FAIL random c=%0d: step=%0d arrow=%b strb=%b rd=%b busy=%b done=%b required %0d %b %b %b %b %b",
                 c, step, arrow, strobe, round_done, busy, done,
                 m_step, m_arrow, m_strobe, m_rd, m_mode == 1, m_mode == 2);
        n_errors++;
      end
    end
    start = 1'b0; stop = 1'b0; pause = 1'b0; wr_en = 1'b0;
  endtask

  initial begin
    test_reset();
    test_song();
    test_pause_stop();
    test_read_before_write();
    test_idle_done_start();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
